// File: rtl/seq_chunk_adder_if.sv
// ============================================================================
// seq_chunk_adder_if : start/busy/done handshake and operand/result bus
// Rev 1.0 -- ovf member present only with SEQ_CHUNK_ADDER_OVF_EN
// ============================================================================
`default_nettype none

interface seq_chunk_adder_if #(
    parameter int WIDTH = 7
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a_in, b_in, ci,
                    input  busy, done, sum, co, ovf);
    modport slave  (input  start, a_in, b_in, ci,
                    output busy, done, sum, co, ovf);
`else
    modport master (output start, a_in, b_in, ci,
                    input  busy, done, sum, co);
    modport slave  (input  start, a_in, b_in, ci,
                    output busy, done, sum, co);
`endif
endinterface

`default_nettype wire

// File: rtl/seq_chunk_adder.sv
// ============================================================================
// seq_chunk_adder : digit-serial adder, CHUNK bits per clock, LSB chunk first
// Rev 1.0 -- optional signed-overflow output via SEQ_CHUNK_ADDER_OVF_EN
// ============================================================================
`default_nettype none

module seq_chunk_adder #(
    parameter int WIDTH = 7,
    parameter int CHUNK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_chunk_adder_if.slave  bus
);
    localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW = N * CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // Position of bit WIDTH inside the last chunk's (CHUNK+1)-bit sum
    localparam int LB = WIDTH - (N - 1) * CHUNK;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_busy;
    logic             w_done;
    logic             w_accept;

    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;

    int               w_base;
    logic [CHUNK:0]   w_psum;
    logic [WIDTH-1:0] w_work;
    logic             w_co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.start;
                if (bus.start) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == LAST) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_accept     = bus.start;
                w_state_next = bus.start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand pad bits are zero, so bit LB of the last chunk sum is the carry into WIDTH
    always_comb begin
        w_base = int'(r_cnt) * CHUNK;
        w_psum = (CHUNK+1)'(r_a[w_base +: CHUNK]) + (CHUNK+1)'(r_b[w_base +: CHUNK])
               + (CHUNK+1)'(r_carry);
        w_work = r_work;
        for (int i = 0; i < CHUNK; i++) begin
            if (w_base + i < WIDTH) w_work[w_base + i] = w_psum[i];
        end
        w_co = w_psum[LB];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= PW'(bus.a_in);
            r_b     <= PW'(bus.b_in);
            r_carry <= bus.ci;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_work  <= w_work;
            r_carry <= w_psum[CHUNK];
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_sum <= w_work;
                r_co  <= w_co;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.co   = r_co;

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic r_ovf;

    // Carry into the MSB is recovered as sum ^ a ^ b at that bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (!w_accept && r_state == S_RUN && r_cnt == LAST) begin
            r_ovf <= w_co ^ w_work[WIDTH-1] ^ r_a[WIDTH-1] ^ r_b[WIDTH-1];
        end
    end

    assign bus.ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// ============================================================================
// tb_seq_chunk_adder : directed + swept checks on WIDTH=7, CHUNK = 1/2/3/7
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_chunk_adder;
    localparam int W = 7;
    localparam int CHUNKS [4] = '{1, 2, 3, 7};
    localparam int LAT    [4] = '{8, 5, 4, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         ci;

    logic [W-1:0] o_sum  [4];
    logic         o_co   [4];
    logic         o_busy [4];
    logic         o_done [4];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic         o_ovf  [4];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seq_chunk_adder_if #(.WIDTH(W)) bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign bus[g].start = start;
        assign bus[g].a_in  = a;
        assign bus[g].b_in  = b;
        assign bus[g].ci    = ci;
        assign o_sum[g]     = bus[g].sum;
        assign o_co[g]      = bus[g].co;
        assign o_busy[g]    = bus[g].busy;
        assign o_done[g]    = bus[g].done;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        assign o_ovf[g]     = bus[g].ovf;
`endif
        seq_chunk_adder #(.WIDTH(W), .CHUNK(CHUNKS[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g])
        );
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if ({o_busy[g], o_done[g], o_co[g], o_sum[g]} !== 10'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: busy=%b done=%b co=%b sum=%b, required all 0",
                         g, o_busy[g], o_done[g], o_co[g], o_sum[g]);
            end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            n_checks++;
            if (o_ovf[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ovf[%0d]: ovf=%b, required 0", g, o_ovf[g]);
            end
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        a = 7'b0000001; b = 7'b0000010; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({o_busy[0], o_done[0]} !== 2'b10) begin
                n_fail++;
                $display("FAIL basic_busy cycle %0d: busy=%b done=%b, required busy=1 done=0",
                         i, o_busy[0], o_done[0]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({o_busy[0], o_done[0], o_co[0], o_sum[0]} !== {3'b010, 7'b0000011}) begin
            n_fail++;
            $display("FAIL basic_done: busy=%b done=%b co=%b sum=%b, required 0 1 0 0000011",
                     o_busy[0], o_done[0], o_co[0], o_sum[0]);
        end
        @(negedge clk);
        n_checks++;
        if ({o_done[0], o_sum[0]} !== {1'b0, 7'b0000011}) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b sum=%b, required done=0 sum=0000011",
                     o_done[0], o_sum[0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        a = 7'b1111111; b = 7'b1111111; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if ({o_done[0], o_co[0], o_sum[0]} !== {2'b11, 7'b1111111}) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b co=%b sum=%b, required 1 1 1111111",
                     o_done[0], o_co[0], o_sum[0]);
        end
        a = 7'b1010101; b = 7'b0000001; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (o_done[0] !== 1'b1 && lat < 20) begin
            n_checks++;
            if ({o_co[0], o_sum[0]} !== {1'b1, 7'b1111111}) begin
                n_fail++;
                $display("FAIL b2b_hold: co=%b sum=%b, required previous 1 1111111",
                         o_co[0], o_sum[0]);
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL b2b_latency: second done after %0d cycles, required 8", lat);
        end
        n_checks++;
        if ({o_co[0], o_sum[0]} !== {1'b0, 7'b1010111}) begin
            n_fail++;
            $display("FAIL b2b_second: co=%b sum=%b, required 0 1010111", o_co[0], o_sum[0]);
        end
    endtask

    task automatic test_chunk3();
        repeat (10) @(negedge clk);
        a = 7'b1110000; b = 7'b0000001; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({o_busy[2], o_done[2]} !== 2'b10) begin
                n_fail++;
                $display("FAIL c3_busy cycle %0d: busy=%b done=%b, required 1 0",
                         i, o_busy[2], o_done[2]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({o_done[2], o_co[2], o_sum[2]} !== {2'b10, 7'b1110010}) begin
            n_fail++;
            $display("FAIL c3_first: done=%b co=%b sum=%b, required 1 0 1110010",
                     o_done[2], o_co[2], o_sum[2]);
        end
        a = 7'b1111111; b = 7'b0000001; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_done[2], o_co[2], o_sum[2]} !== {2'b11, 7'b0000000}) begin
            n_fail++;
            $display("FAIL c3_pad_carry: done=%b co=%b sum=%b, required 1 1 0000000",
                     o_done[2], o_co[2], o_sum[2]);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        repeat (10) @(negedge clk);
        a = 7'b0101010; b = 7'b0001010; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 7'b1111111; b = 7'b1111111; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; ci = 1'b0;
        lat = 4;
        while (o_done[0] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL ignore_latency: done after %0d cycles, required 8", lat);
        end
        n_checks++;
        if ({o_co[0], o_sum[0]} !== {1'b0, 7'b0110100}) begin
            n_fail++;
            $display("FAIL ignore_result: co=%b sum=%b, required 0 0110100", o_co[0], o_sum[0]);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a = 7'b0011001; b = 7'b1111111; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_busy[0], o_done[0], o_co[0], o_sum[0]} !== 10'b0) begin
            n_fail++;
            $display("FAIL abort_async: busy=%b done=%b co=%b sum=%b, required all 0",
                     o_busy[0], o_done[0], o_co[0], o_sum[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o_done[0], o_busy[0], o_sum[0]} !== 9'b0) begin
                n_fail++;
                $display("FAIL abort_quiet cycle %0d: done=%b busy=%b sum=%b, required 0 0 0",
                         i, o_done[0], o_busy[0], o_sum[0]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [W:0]   expv;
        logic [W-1:0] prev_sum [4];
        logic         prev_co  [4];
        int           cnt      [4];
        int           at       [4];
        for (int op = 0; op < 2000; op++) begin
            a  = W'($urandom_range(0, 127));
            b  = W'($urandom_range(0, 127));
            ci = 1'($urandom_range(0, 1));
            expv = {1'b0, a} + {1'b0, b} + {7'b0, ci};
            for (int g = 0; g < 4; g++) begin
                prev_sum[g] = o_sum[g]; prev_co[g] = o_co[g]; cnt[g] = 0; at[g] = 0;
            end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            a = ~a; b = ~b; ci = ~ci;
            for (int c = 1; c <= 9; c++) begin
                for (int g = 0; g < 4; g++) begin
                    n_checks++;
                    if (o_done[g] === 1'b1) begin
                        cnt[g]++; at[g] = c;
                        if ({o_co[g], o_sum[g]} !== expv) begin
                            n_fail++;
                            $display("FAIL sweep_result[chunk %0d] op %0d: got %b_%b, required %b",
                                     CHUNKS[g], op, o_co[g], o_sum[g], expv);
                        end
                        prev_sum[g] = o_sum[g]; prev_co[g] = o_co[g];
                    end else if ({o_co[g], o_sum[g]} !== {prev_co[g], prev_sum[g]}) begin
                        n_fail++;
                        $display("FAIL sweep_stable[chunk %0d] op %0d: %b_%b changed from %b_%b",
                                 CHUNKS[g], op, o_co[g], o_sum[g], prev_co[g], prev_sum[g]);
                    end
                end
                @(negedge clk);
            end
            for (int g = 0; g < 4; g++) begin
                n_checks++;
                if (cnt[g] !== 1 || at[g] !== LAT[g]) begin
                    n_fail++;
                    $display("FAIL sweep_done[chunk %0d] op %0d: %0d pulses at cycle %0d, required 1 at %0d",
                             CHUNKS[g], op, cnt[g], at[g], LAT[g]);
                end
            end
        end
    endtask

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    task automatic test_ovf();
        repeat (10) @(negedge clk);
        a = 7'b0111111; b = 7'b0000001; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_done[2], o_co[2], o_ovf[2], o_sum[2]} !== {3'b101, 7'b1000000}) begin
            n_fail++;
            $display("FAIL ovf_pos: done=%b co=%b ovf=%b sum=%b, required 1 0 1 1000000",
                     o_done[2], o_co[2], o_ovf[2], o_sum[2]);
        end
        a = 7'b1111111; b = 7'b0000001; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_done[2], o_co[2], o_ovf[2], o_sum[2]} !== {3'b110, 7'b0000000}) begin
            n_fail++;
            $display("FAIL ovf_neg: done=%b co=%b ovf=%b sum=%b, required 1 1 0 0000000",
                     o_done[2], o_co[2], o_ovf[2], o_sum[2]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_chunk3();
        test_start_ignored();
        test_reset_abort();
        test_sweep();
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
